fp_inv_square: RTL and testbench
================================

// Module: fp_inv_square
// PURPOSE
//  Computes x = 1/y^2 in 16-bit signed Q8.7 fixed point (1.0 = 16'h0080).
//  This is the inverse mapping of the inverse-square-root datapath, so it
//  recovers magnitudes from invsqrt results.
//  Multi-cycle: one squaring cycle, then a restoring divider, with a valid/ready handshake.
//  Sits between the vector-normalisation datapath and the Nios-visible result registers.
// PARAMETERS
//  WIDTH     16  operand/result width (Q8.7); only 16 is supported
//  FRAC      7   fractional bits
//  DIV_ITERS 22  restoring-division iterations (quotient bits 21..0 of 2^21/Y^2)
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-high
//  in_valid   in   1   operand y is valid
//  in_ready   out  1   block can accept an operand (high only in IDLE)
//  in_y       in   16  operand y, signed Q8.7
//  out_valid  out  1   result is valid; held until accepted
//  out_ready  in   1   consumer accepts the result
//  out_x      out  16  result 1/y^2, signed Q8.7; always non-negative
//  out_sat    out  1   result saturated to 16'h7FFF
//  out_div0   out  1   y was zero
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready, which is 1. FSM goes to IDLE.
//  Reset mid-operation aborts silently; no result is produced.
//  FSM:
//   IDLE -> SQUARE on in_valid. y is captured; |y| is used, so -32768 maps to 32768.
//   IDLE -> DONE when y==0: out_x=16'h7FFF, out_sat=1, out_div0=1; divider is skipped.
//   SQUARE (1 cycle): D = |Y|*|Y|, 31-bit unsigned, full precision, no truncation.
//   DIVIDE (DIV_ITERS cycles): restoring division of 2^21 by D, MSB first.
//     A 32-bit partial remainder holds one quotient bit per cycle.
//     An iteration counter counts DIV_ITERS-1 down to 0.
//   DONE: out_valid=1; out_x, out_sat and out_div0 are stable.
//     DONE -> IDLE on out_ready; out_valid drops on the next edge.
//  Saturation: a 22-bit quotient Q > 16'h7FFF gives out_x=16'h7FFF, out_sat=1.
//    Otherwise out_x = Q[15:0].
//  Latency: handshake at edge 0 -> out_valid at edge 1+1+DIV_ITERS (24).
//    The y==0 case gives out_valid at edge 1.
//  Throughput: one operation in flight. in_valid outside IDLE is ignored; the producer holds it.
//  out_ready high before out_valid has no effect.
//  Same-cycle out_ready and in_valid in DONE: only the result is consumed.
//    in_ready goes high one cycle later.
// CONFIGURATION
//  FP_INV_SQUARE_ROUND_EN defined:
//    One extra iteration (DIV_ITERS+1), latency 25.
//    Quotient rounded to nearest, ties away from zero, before the saturation check.
//  Not defined: the quotient is truncated toward zero; latency 24.
// STRUCTURE
//  Shared package fp_pkg:
//    Q8.7 constants FP_ONE=16'h0080, FP_MAX=16'h7FFF, FP_FRAC=7
//    FSM state encoding (IDLE, SQUARE, DIVIDE, DONE)
//  Sub-module fp_div_step: combinational restoring step.
//    Inputs: remainder, divisor, next dividend bit.
//    Outputs: new remainder, quotient bit.
//    Instantiated once and used iteratively.
// TESTING
//  y=16'h0080 (1.0) -> out_x=16'h0080, sat=0, div0=0, out_valid 24 cycles after accept.
//  y=16'h0100 (2.0) -> 16'h0020. y=16'h0040 (0.5) -> 16'h0200. y=16'hFF00 (-2.0) -> 16'h0020.
//  y=16'h0180 (3.0) -> 16'h000E with or without rounding.
//    y=16'h00B5 -> 16'h0040.
//  y=16'h0000 -> 16'h7FFF, sat=1, div0=1, out_valid 1 cycle after accept.
//    y=16'h0001 -> 16'h7FFF, sat=1, div0=0.
//  out_ready held low 10 cycles in DONE -> out_valid and out_x stable; in_ready stays 0.
//    A second in_valid meanwhile is not accepted.
//  reset pulsed at DIVIDE iteration 10 -> outputs 0 and in_ready 1 immediately.
//    The next operation, y=16'h0100, gives 16'h0020.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_pkg
// Brief   : Shared Q8.7 constants and FSM state encoding for the
//           fixed-point inverse-square datapath.
// Revision: 1.0  initial release
// ============================================================================
package fp_pkg;

    // Q8.7 constants
    localparam logic [15:0] FP_ONE  = 16'h0080;
    localparam logic [15:0] FP_MAX  = 16'h7FFF;
    localparam int          FP_FRAC = 7;

    // FSM state encoding
    localparam int          c_ST_W      = 2;
    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_SQUARE = 2'd1;
    localparam logic [1:0]  c_ST_DIVIDE = 2'd2;
    localparam logic [1:0]  c_ST_DONE   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fp_div_step.sv
`default_nettype none
// ============================================================================
// Module  : fp_div_step
// Brief   : One combinational restoring-division step. Shifts the next
//           dividend bit into the partial remainder and subtracts the
//           divisor when it fits, producing one quotient bit.
// Revision: 1.0  initial release
// ============================================================================
module fp_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_div,
    input  logic         i_bit,
    output logic [W-1:0] o_rem,
    output logic         o_qbit
);

    logic [W-1:0] w_shift;
    logic         w_ge;

    // Shift in the dividend bit; the bit shifted out still counts in the compare.
    always_comb begin
        w_shift = {i_rem[W-2:0], i_bit};
        w_ge    = i_rem[W-1] | (w_shift >= i_div);
        o_qbit  = w_ge;
        o_rem   = w_ge ? (w_shift - i_div) : w_shift;
    end

endmodule
`default_nettype wire

// File: rtl/fp_inv_square.sv
`default_nettype none
// ============================================================================
// Module  : fp_inv_square
// Brief   : x = 1/y^2 in signed Q8.7. One squaring cycle followed by a
//           restoring divider computing 2^21 / |y|^2, valid/ready handshake.
//           Optional macro FP_INV_SQUARE_ROUND_EN: one extra quotient bit,
//           round to nearest (ties away from zero) before saturation.
// Revision: 1.0  initial release
// ============================================================================
module fp_inv_square #(
    parameter int WIDTH     = 16,
    parameter int FRAC      = 7,
    parameter int DIV_ITERS = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic             out_sat,
    output logic             out_div0
);
    import fp_pkg::*;

`ifdef FP_INV_SQUARE_ROUND_EN
    localparam int c_ITERS = DIV_ITERS + 1;
`else
    localparam int c_ITERS = DIV_ITERS;
`endif
    // Divisor and remainder hold the full |y|^2 product.
    localparam int c_DW    = 2 * WIDTH;
    localparam int c_CNT_W = $clog2(c_ITERS);
    // Counter value at which the single set bit of the dividend 2^(3*FRAC)
    // enters the remainder; the rounding bit sits one position below it.
    localparam int c_ONE_POS = 3 * FRAC + (c_ITERS - DIV_ITERS);

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_next;
    logic [WIDTH-1:0]   w_abs;
    logic [WIDTH-1:0]   r_mag;
    logic [c_DW-1:0]    r_den;
    logic [c_DW-1:0]    r_rem;
    logic [c_DW-1:0]    w_rem_nxt;
    logic               w_qbit;
    logic               w_num_bit;
    logic [c_ITERS-2:0] r_quo;
    logic [c_ITERS-1:0] w_qfull;
    logic [c_ITERS-1:0] w_qres;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_last;
    logic               w_sat;
    logic               w_accept;
    logic               w_zero;

    // |y| fits unsigned in WIDTH bits, so -32768 becomes 16'h8000.
    assign w_abs     = in_y[WIDTH-1] ? -in_y : in_y;
    assign w_accept  = (r_state == c_ST_IDLE) && in_valid;
    assign w_zero    = (in_y == '0);
    assign w_last    = (r_state == c_ST_DIVIDE) && (r_cnt == '0);
    assign w_num_bit = (r_cnt == c_CNT_W'(c_ONE_POS));
    assign w_qfull   = {r_quo, w_qbit};

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_DONE);

    fp_div_step #(
        .W (c_DW)
    ) u_step (
        .i_rem  (r_rem),
        .i_div  (r_den),
        .i_bit  (w_num_bit),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

`ifdef FP_INV_SQUARE_ROUND_EN
    // Drop the extra half-LSB bit, adding it back as the rounding increment.
    assign w_qres = {1'b0, w_qfull[c_ITERS-1:1]} + {{(c_ITERS-1){1'b0}}, w_qfull[0]};
`else
    assign w_qres = w_qfull;
`endif

    // Anything at or above bit WIDTH-1 exceeds the positive Q8.7 range.
    assign w_sat = |w_qres[c_ITERS-1:WIDTH-1];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; a zero operand bypasses the divider.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (in_valid) w_next = w_zero ? c_ST_DONE : c_ST_SQUARE;
            c_ST_SQUARE: w_next = c_ST_DIVIDE;
            c_ST_DIVIDE: if (r_cnt == '0) w_next = c_ST_DONE;
            c_ST_DONE:   if (out_ready) w_next = c_ST_IDLE;
            default:     w_next = c_ST_IDLE;
        endcase
    end

    // Operand capture, squaring and one divider iteration per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mag <= '0;
            r_den <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_mag <= w_abs;
            end
            if (r_state == c_ST_SQUARE) begin
                r_den <= {{WIDTH{1'b0}}, r_mag} * {{WIDTH{1'b0}}, r_mag};
                r_rem <= '0;
                r_quo <= '0;
                r_cnt <= c_CNT_W'(c_ITERS - 1);
            end else if (r_state == c_ST_DIVIDE) begin
                r_rem <= w_rem_nxt;
                r_quo <= {r_quo[c_ITERS-3:0], w_qbit};
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
            end
        end
    end

    // Result registers, loaded on entry to DONE and held until the next result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_x    <= '0;
            out_sat  <= 1'b0;
            out_div0 <= 1'b0;
        end else if (w_accept && w_zero) begin
            out_x    <= FP_MAX;
            out_sat  <= 1'b1;
            out_div0 <= 1'b1;
        end else if (w_last) begin
            out_x    <= w_sat ? FP_MAX : w_qres[WIDTH-1:0];
            out_sat  <= w_sat;
            out_div0 <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_inv_square.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_inv_square
// Brief   : Directed, table-driven self-checking bench for fp_inv_square.
// Revision: 1.0  initial release
// ============================================================================
module tb_fp_inv_square;
    import fp_pkg::*;

`ifdef FP_INV_SQUARE_ROUND_EN
    localparam int c_LAT = 25;
`else
    localparam int c_LAT = 24;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic        out_sat;
    logic        out_div0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] y;
        logic [15:0] x;
        logic        sat;
        logic        div0;
    } vec_t;

    vec_t vecs [13];

    fp_inv_square dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_sat   (out_sat),
        .out_div0  (out_div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Present y, wait for acceptance, then count cycles to out_valid.
    task automatic do_op(input logic [15:0] y, output int lat);
        int n;
        in_y     = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = n + 1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;

        vecs[0]  = '{16'h0080, 16'h0080, 1'b0, 1'b0};
        vecs[1]  = '{16'h0100, 16'h0020, 1'b0, 1'b0};
        vecs[2]  = '{16'h0040, 16'h0200, 1'b0, 1'b0};
        vecs[3]  = '{16'hFF00, 16'h0020, 1'b0, 1'b0};
        vecs[4]  = '{16'h0180, 16'h000E, 1'b0, 1'b0};
        vecs[5]  = '{16'h00B5, 16'h0040, 1'b0, 1'b0};
        vecs[6]  = '{16'h0000, 16'h7FFF, 1'b1, 1'b1};
        vecs[7]  = '{16'h0001, 16'h7FFF, 1'b1, 1'b0};
        vecs[8]  = '{16'h0008, 16'h7FFF, 1'b1, 1'b0};
        vecs[9]  = '{16'h8000, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{16'h0200, 16'h0008, 1'b0, 1'b0};
        vecs[11] = '{16'h0010, 16'h2000, 1'b0, 1'b0};
        vecs[12] = '{16'hFFC0, 16'h0200, 1'b0, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_y      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_x",     32'(out_x),     32'd0);
        check("reset_out_sat",   32'(out_sat),   32'd0);
        check("reset_out_div0",  32'(out_div0),  32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].y, lat);
            check($sformatf("x[y=%h]", vecs[i].y),    32'(out_x),    32'(vecs[i].x));
            check($sformatf("sat[y=%h]", vecs[i].y),  32'(out_sat),  32'(vecs[i].sat));
            check($sformatf("div0[y=%h]", vecs[i].y), 32'(out_div0), 32'(vecs[i].div0));
            check($sformatf("lat[y=%h]", vecs[i].y),  32'(lat),      vecs[i].div0 ? 32'd1 : 32'(c_LAT));
            consume();
            check($sformatf("idle_after[y=%h]", vecs[i].y), {30'd0, in_ready, out_valid}, 32'b10);
        end

        // Result held in DONE while the consumer stalls; a new operand waits.
        do_op(16'h0100, lat);
        in_y     = 16'h0080;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("hold_c%0d", c), {out_valid, in_ready, 14'd0, out_x}, {1'b1, 1'b0, 14'd0, 16'h0020});
            @(posedge clk);
            #1;
        end
        // Same-cycle out_ready and in_valid: only the result is consumed.
        consume();
        check("consume_vs_in_valid", {30'd0, in_ready, out_valid}, 32'b10);
        do_op(16'h0080, lat);
        check("second_op_x",   32'(out_x), 32'h0080);
        check("second_op_lat", 32'(lat),   32'(c_LAT));
        consume();

        // Reset during divide iteration 10 aborts the operation.
        in_y     = 16'h0180;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_outputs", {27'd0, in_ready, out_valid, out_sat, out_div0, |out_x}, 32'b10000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 30; c++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            check("midrst_no_result", 32'(seen), 32'd0);
        end
        do_op(16'h0100, lat);
        check("post_rst_x",   32'(out_x),   32'h0020);
        check("post_rst_sat", 32'(out_sat), 32'd0);
        check("post_rst_lat", 32'(lat),     32'(c_LAT));
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
